// File: rtl/wb_mem_responder.sv
// Word-addressed RAM slave: captures one request, waits WAIT_CYCLES, then answers with a one-cycle W_ACK.
// Optional macro WB_MEM_ERR_CHECK_EN adds W_ERR and rejects out-of-range addresses instead of wrapping.
//
// state | meaning
// IDLE  | waiting for W_STB; captures the request on the sampling edge
// WAIT  | wait-state down-counter running; bus inputs ignored
// RESP  | RAM access done on entry; W_ACK (or W_ERR) high for this one cycle
module wb_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_STB,
  input  logic        W_WRITE,
  input  logic [31:0] W_ADDR,
  input  logic [31:0] W_DATA_I,
  output logic [31:0] W_DATA_O,
  output logic        W_ACK
`ifdef WB_MEM_ERR_CHECK_EN
  ,
  output logic        W_ERR
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdata_q;
  logic           write_q;
  logic           oor_q;
  logic           capture;
  logic           enter_resp;

  logic [31:0]    mem [DEPTH];

  // With zero wait states the RAM access happens on the capture edge, so use the live bus.
  logic           in_idle;
  logic [AW-1:0]  cur_idx;
  logic [31:0]    cur_wdata;
  logic           cur_write;
  logic           cur_oor;
  logic           err_cond;
  logic           mem_we;
  logic [31:0]    rd_word;
  logic           unused_bits;

  assign in_idle   = (state_q == IDLE);
  assign cur_idx   = in_idle ? W_ADDR[AW+1:2] : idx_q;
  assign cur_wdata = in_idle ? W_DATA_I : wdata_q;
  assign cur_write = in_idle ? W_WRITE : write_q;
  assign cur_oor   = in_idle ? (|W_ADDR[31:AW+2]) : oor_q;

`ifdef WB_MEM_ERR_CHECK_EN
  assign err_cond    = cur_oor;
  assign unused_bits = ^W_ADDR[1:0];
`else
  assign err_cond    = 1'b0;
  assign unused_bits = ^{W_ADDR[1:0], cur_oor};
`endif

  assign rd_word = mem[cur_idx];
  // Gate with rst_n so a reset held across the edge drops any pending write.
  assign mem_we  = enter_resp & cur_write & ~err_cond & rst_n;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (W_STB) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      oor_q    <= 1'b0;
      W_ACK    <= 1'b0;
      W_DATA_O <= '0;
`ifdef WB_MEM_ERR_CHECK_EN
      W_ERR    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      W_ACK   <= enter_resp & ~err_cond;
`ifdef WB_MEM_ERR_CHECK_EN
      W_ERR   <= enter_resp & err_cond;
`endif
      if (capture) begin
        idx_q   <= W_ADDR[AW+1:2];
        wdata_q <= W_DATA_I;
        write_q <= W_WRITE;
        oor_q   <= |W_ADDR[31:AW+2];
      end
      if (enter_resp && !cur_write) begin
        W_DATA_O <= err_cond ? 32'd0 : rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

endmodule
